mem_read_sequencer: RTL and testbench

MEM_READ_SEQUENCER -- requirements
Module: mem_read_sequencer

---
 rtl/mem_seq_pkg.sv | 17 +
 rtl/seq_skid_fifo.sv | 74 +++++++
 rtl/mem_read_sequencer.sv | 146 ++++++++++++++
 tb/tb_mem_read_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg
// Shared definitions for the memory read sequencer:
//   seq_state_e - burst controller states
//   FIFO_DEPTH  - depth of the output buffer. The credit logic in the top
//                 allows at most this many words to be buffered or in flight.
package mem_seq_pkg;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_skid_fifo.sv
// seq_skid_fifo
// Two-entry output buffer between the RAM read pipeline and the consumer.
// The buffer accepts a write and a pop in the same cycle, and a flush empties it.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   push, wdata  - write a word (ignored if full without a simultaneous pop)
//   pop          - remove the head word (ignored if empty)
//   flush        - drop all contents; takes priority over push/pop
//   rdata        - head word
//   full, empty  - occupancy flags
//   count        - number of stored words (0..2)
module seq_skid_fifo
  import mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            count
);

  localparam logic [1:0] DEPTH_CNT = 2'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  wrPtr_q;
  logic                  rdPtr_q;
  logic [1:0]            count_q;
  logic                  doPush;
  logic                  doPop;

  // A pop frees a slot in the same cycle, so a full buffer can still take a write
  // while it is being read.
  assign doPop  = pop && (count_q != 2'd0);
  assign doPush = push && ((count_q != DEPTH_CNT) || doPop);

  assign rdata = mem_q[rdPtr_q];
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

  // Storage and pointers. Depth 2 lets one-bit pointers simply toggle.
  // A flush resets only the pointers and leaves stale storage in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= wdata;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (doPop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_q + {1'b0, doPush} - {1'b0, doPop};
    end
  end

endmodule

// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer
// Reads a burst of consecutive RAM words and streams them to a ready/valid
// consumer. Credit logic limits buffered plus in-flight words to the buffer
// depth, so the RAM pipeline never overruns the output buffer.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start, base_addr,
//   count               - begin a burst of count words at base_addr (idle only)
//   abort               - flush the burst in progress and return to idle
//   mem_we, mem_addr    - RAM control (read-only, registered address)
//   mem_dout            - registered RAM data, one cycle after the address
//   out_data, out_valid,
//   out_ready           - output stream; a word moves when valid and ready are both 1
//   busy, done          - not-idle flag and one-cycle burst-complete pulse
module mem_read_sequencer
  import mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  abort,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;

  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [1:0]            fifoCount;
  logic [2:0]            occupied;
  logic                  pop;
  logic                  credit;
  logic                  issue;

  assign mem_we    = 1'b0;
  assign mem_addr  = addr_q;
  assign out_valid = !fifoEmpty;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);

  assign pop      = out_valid && out_ready;
  assign occupied = {1'b0, fifoCount} + {2'b0, inflight_q};
  // A pop in this cycle frees a slot in time for the read issued now.
  assign credit   = pop || (!fifoFull && (occupied < 3'(FIFO_DEPTH)));
  assign issue    = (state_q == RUN) && (remaining_q != '0) && credit && !abort;

  // The read issued last cycle delivers its word now. On abort the word is dropped.
  seq_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q && !abort),
    .pop   (pop),
    .flush (abort),
    .wdata (mem_dout),
    .rdata (out_data),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // State, address, word counter and read-in-flight flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
    end
  end

  // Next-state logic. Abort overrides everything, including start.
  // An empty burst skips RUN and leaves the address register untouched.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    inflight_d  = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              state_d = FINISH;
            end else begin
              state_d     = RUN;
              addr_d      = base_addr;
              remaining_d = count;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_d      = addr_q + ADDR_ONE;
            remaining_d = remaining_q - REM_ONE;
            inflight_d  = 1'b1;
            if (remaining_q == REM_ONE) begin
              state_d = DRAIN;
            end
          end else if (remaining_q == '0) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight_q && fifoEmpty) begin
            state_d = FINISH;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_sequencer.sv
// tb_mem_read_sequencer
// Directed bench for mem_read_sequencer with a registered RAM model where
// ram[i] = i[7:0].
module tb_mem_read_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] base_addr;
  logic [10:0] count;
  logic       abort;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_dout;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int checks;
  int failures;
  int doneCount;

  logic [7:0] ram [1024];

  mem_read_sequencer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .abort     (abort),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with a registered read port.
  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'(i);
    end
  end
  always @(posedge clk) mem_dout <= ram[mem_addr];

  // done pulses are counted mid-cycle, away from the active edge.
  initial doneCount = 0;
  always @(negedge clk) if (done === 1'b1) doneCount++;

  // Wait for the next edge and settle just after it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Drive all control inputs, then advance one clock.
  task automatic applyStimulus(input logic st, input logic [9:0] base, input logic [10:0] cnt,
                               input logic ab, input logic rdy);
    start     = st;
    base_addr = base;
    count     = cnt;
    abort     = ab;
    out_ready = rdy;
    stepClock();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance until done pulses, within a bounded number of cycles, then
  // step once more so the block is back in IDLE.
  task automatic waitDone(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      stepClock();
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
    stepClock();
  endtask

  initial begin
    int         accepted;
    int         cyc;
    int         doneBefore;
    logic       holdPending;
    logic [7:0] heldData;
    logic [7:0] expByte;
    logic [9:0] ahead;
    logic [9:0] addrBefore;

    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    abort     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_addr", {22'd0, mem_addr}, 32'd0);
    checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_data", {24'd0, out_data}, 32'd0);
    reset = 1'b0;
    stepClock();

    // Basic burst: base 0x010, 4 words, consumer always ready
    doneBefore = doneCount;
    applyStimulus(1'b1, 10'h010, 11'd4, 1'b0, 1'b1);          // edge N
    start = 1'b0;
    checkOutput("b1_busy", {31'd0, busy}, 32'd1);
    checkOutput("b1_addr0", {22'd0, mem_addr}, 32'h010);
    checkOutput("b1_valid_n", {31'd0, out_valid}, 32'd0);
    stepClock();                                              // N+1
    checkOutput("b1_valid_n1", {31'd0, out_valid}, 32'd0);
    checkOutput("b1_addr1", {22'd0, mem_addr}, 32'h011);
    stepClock();                                              // N+2
    checkOutput("b1_valid_n2", {31'd0, out_valid}, 32'd1);
    checkOutput("b1_w0", {24'd0, out_data}, 32'h10);
    stepClock();
    checkOutput("b1_w1", {24'd0, out_data}, 32'h11);
    stepClock();
    checkOutput("b1_w2", {24'd0, out_data}, 32'h12);
    stepClock();                                              // N+5
    checkOutput("b1_w3", {24'd0, out_data}, 32'h13);
    checkOutput("b1_w3_valid", {31'd0, out_valid}, 32'd1);
    stepClock();                                              // N+6
    checkOutput("b1_empty", {31'd0, out_valid}, 32'd0);
    checkOutput("b1_done_early", {31'd0, done}, 32'd0);
    stepClock();                                              // N+7
    checkOutput("b1_done", {31'd0, done}, 32'd1);
    stepClock();                                              // N+8
    checkOutput("b1_done_clr", {31'd0, done}, 32'd0);
    checkOutput("b1_idle", {31'd0, busy}, 32'd0);
    checkOutput("b1_done_once", 32'(doneCount - doneBefore), 32'd1);

    // Address wrap: base 0x3FE, 4 words
    applyStimulus(1'b1, 10'h3FE, 11'd4, 1'b0, 1'b1);
    start = 1'b0;
    stepClock();
    checkOutput("wr_addr1", {22'd0, mem_addr}, 32'h3FF);
    stepClock();
    checkOutput("wr_addr2", {22'd0, mem_addr}, 32'h000);
    checkOutput("wr_w0", {24'd0, out_data}, 32'hFE);
    stepClock();
    checkOutput("wr_w1", {24'd0, out_data}, 32'hFF);
    stepClock();
    checkOutput("wr_w2", {24'd0, out_data}, 32'h00);
    stepClock();
    checkOutput("wr_w3", {24'd0, out_data}, 32'h01);
    waitDone("wr_done");

    // Backpressure: 8 words at 0x020, random ready with a 10-cycle stall
    doneBefore  = doneCount;
    accepted    = 0;
    holdPending = 1'b0;
    heldData    = '0;
    cyc         = 0;
    applyStimulus(1'b1, 10'h020, 11'd8, 1'b0, 1'b0);
    start = 1'b0;
    while (doneCount == doneBefore && cyc < 200) begin
      out_ready = (cyc >= 2 && cyc < 12) ? 1'b0 : 1'($urandom_range(0, 1));
      if (holdPending) begin
        checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_hold_data", {24'd0, out_data}, {24'd0, heldData});
      end
      if (out_valid === 1'b1 && out_ready) begin
        expByte = 8'(32'h20 + accepted);
        checkOutput("bp_order", {24'd0, out_data}, {24'd0, expByte});
        accepted++;
      end
      holdPending = (out_valid === 1'b1) && !out_ready;
      heldData    = out_data;
      stepClock();
      ahead = 10'(mem_addr - 10'h020 - 10'(accepted));
      checkOutput("bp_credit", {31'd0, (ahead <= 10'd2)}, 32'd1);
      cyc++;
    end
    out_ready = 1'b1;
    stepClock();
    stepClock();
    checkOutput("bp_count", 32'(accepted), 32'd8);
    checkOutput("bp_done_once", 32'(doneCount - doneBefore), 32'd1);

    // Empty burst
    addrBefore = mem_addr;
    doneBefore = doneCount;
    applyStimulus(1'b1, 10'h055, 11'd0, 1'b0, 1'b1);
    start = 1'b0;
    checkOutput("z_done", {31'd0, done}, 32'd1);
    checkOutput("z_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("z_addr", {22'd0, mem_addr}, {22'd0, addrBefore});
    stepClock();
    checkOutput("z_done_clr", {31'd0, done}, 32'd0);
    checkOutput("z_valid2", {31'd0, out_valid}, 32'd0);
    checkOutput("z_idle", {31'd0, busy}, 32'd0);
    checkOutput("z_done_once", 32'(doneCount - doneBefore), 32'd1);

    // Abort mid-burst, together with a start that must lose to it
    doneBefore = doneCount;
    applyStimulus(1'b1, 10'h030, 11'd16, 1'b0, 1'b1);         // N
    start = 1'b0;
    repeat (5) stepClock();                                   // N+5: 3 words taken
    checkOutput("ab_valid_pre", {31'd0, out_valid}, 32'd1);
    checkOutput("ab_data_pre", {24'd0, out_data}, 32'h33);
    applyStimulus(1'b1, 10'h200, 11'd3, 1'b1, 1'b1);
    checkOutput("ab_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("ab_busy", {31'd0, busy}, 32'd0);
    checkOutput("ab_done", {31'd0, done}, 32'd0);
    applyStimulus(1'b0, 10'h200, 11'd3, 1'b0, 1'b1);
    checkOutput("ab_idle", {31'd0, busy}, 32'd0);
    checkOutput("ab_valid2", {31'd0, out_valid}, 32'd0);
    checkOutput("ab_no_done", 32'(doneCount - doneBefore), 32'd0);
    applyStimulus(1'b1, 10'h040, 11'd2, 1'b0, 1'b1);
    start = 1'b0;
    stepClock();
    stepClock();
    checkOutput("ab_new_w0", {24'd0, out_data}, 32'h40);
    checkOutput("ab_new_v0", {31'd0, out_valid}, 32'd1);
    stepClock();
    checkOutput("ab_new_w1", {24'd0, out_data}, 32'h41);
    waitDone("ab_new_done");

    // Start while busy is ignored; asynchronous reset mid-burst
    doneBefore = doneCount;
    applyStimulus(1'b1, 10'h060, 11'd6, 1'b0, 1'b0);
    start = 1'b0;
    stepClock();
    stepClock();
    applyStimulus(1'b1, 10'h200, 11'd3, 1'b0, 1'b0);
    start = 1'b0;
    checkOutput("ig_addr", {22'd0, mem_addr}, 32'h062);
    checkOutput("ig_data", {24'd0, out_data}, 32'h60);
    checkOutput("ig_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("ar_busy", {31'd0, busy}, 32'd0);
    checkOutput("ar_addr", {22'd0, mem_addr}, 32'd0);
    checkOutput("ar_data", {24'd0, out_data}, 32'd0);
    checkOutput("ar_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stepClock();
    stepClock();
    checkOutput("ar_idle", {31'd0, busy}, 32'd0);
    checkOutput("ar_no_done", 32'(doneCount - doneBefore), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule
